lfsr_seq: RTL

Command-driven sequencer for a 16-bit Galois LFSR pattern generator. A requester loads a tap mask, a seed and a beat count in one handshake. The block then streams that many successive LFSR states over a valid/ready output with backpressure, and signals completion. It sits between a test/config master and the pattern consumer, and is the only agent that configures and advances the LFSR.

---
 rtl/lfsr_pkg.sv | 22 ++
 rtl/lfsr_core.sv | 51 +++++
 rtl/lfsr_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: default widths, sequencer states and the Galois step.
package lfsr_pkg;

  localparam int LFSR_W    = 16;
  localparam int CNT_W_DEF = 16;

  typedef logic [LFSR_W-1:0] lfsr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Galois step with MSB feedback: shift left, XOR taps in when the MSB falls out.
  function automatic lfsr_t lfsr_next(input lfsr_t s, input lfsr_t taps);
    lfsr_t shifted;
    shifted   = {s[LFSR_W-2:0], 1'b0};
    lfsr_next = s[LFSR_W-1] ? (shifted ^ taps) : shifted;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR register: load captures seed and taps, step advances by one state.
// Single-cycle update; no flow control of its own, the sequencer gates step.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int WIDTH = LFSR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] taps,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] taps_q, taps_d;
  logic [WIDTH-1:0] step_val;

  if (WIDTH == LFSR_W) begin : g_pkg_step
    assign step_val = lfsr_next(state_q, taps_q);
  end else begin : g_gen_step
    assign step_val = state_q[WIDTH-1] ? ({state_q[WIDTH-2:0], 1'b0} ^ taps_q)
                                       : {state_q[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    taps_d  = taps_q;
    if (load) begin
      state_d = seed;
      taps_d  = taps;
    end else if (step) begin
      state_d = step_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
      taps_q  <= '0;
    end else begin
      state_q <= state_d;
      taps_q  <= taps_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_seq.sv
// Command-driven LFSR pattern sequencer: first beat one cycle after accept, done one cycle after last beat.
// Output is valid/ready; out_data holds while stalled, only abort or reset drops valid without a handshake.
module lfsr_seq
  import lfsr_pkg::*;
#(
  parameter int WIDTH = LFSR_W,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_taps,
  input  logic [WIDTH-1:0] cmd_seed,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] beats_left
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             lfsr_load;
  logic             lfsr_step;
  logic             reject;

  assign reject = (cmd_count == '0) || (cmd_seed == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          lfsr_load = 1'b1;
          err_d     = (cmd_seed == '0) && (cmd_count != '0);
          if (reject) begin
            state_d = ST_FIN;
            cnt_d   = '0;
          end else begin
            state_d = ST_RUN;
            cnt_d   = cmd_count;
          end
        end
      end
      ST_RUN: begin
        // Abort wins over a same-cycle handshake, so that beat is never counted.
        if (abort) begin
          state_d = ST_FIN;
          err_d   = 1'b0;
        end else if (out_ready) begin
          lfsr_step = 1'b1;
          cnt_d     = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  lfsr_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (cmd_seed),
    .taps  (cmd_taps),
    .state (out_data)
  );

  assign cmd_ready  = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_RUN);
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_FIN);
  assign err        = err_q;
  assign beats_left = cnt_q;

endmodule
